// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the byte-serial memory access unit:
// access size codes, FSM state encoding and small decode helpers.
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    MAU_IDLE  = 2'd0,
    MAU_XFER  = 2'd1,
    MAU_RLAST = 2'd2,
    MAU_DONE  = 2'd3
  } mau_state_t;

  // Number of bytes moved for a size code; code 2'b11 behaves as a word.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // True when the low address bits do not match the natural alignment of the size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load result formatter: keeps the low 8*n bits of the
// gathered bytes and fills the rest with zero or the sign bit.
module load_extend #(
  parameter int N = 32
) (
  input  logic [31:0]  raw,
  input  logic [2:0]   n,
  input  logic         zext,
  output logic [N-1:0] data
);

  logic sign;
  logic fill;

  // Select the sign bit for the access size, then build the extended word.
  always_comb begin
    data = '0;
    case (n)
      3'd1:    sign = raw[7];
      3'd2:    sign = raw[15];
      default: sign = raw[31];
    endcase
    fill = zext ? 1'b0 : sign;
    for (int k = 0; k < N; k++) begin
      data[k] = (k < 8 * int'(n)) ? raw[5'(k)] : fill;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-serial RV32I load/store engine in front of a byte-wide single-port RAM.
// Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses skip the RAM and complete at once with MisalignErr.
//
// Request/Stall/Done handshake: a request (MemRead|MemWrite) is taken only in
// IDLE; Stall is high combinationally from that same cycle until the transfer
// finishes; Done pulses for exactly one cycle; the pipeline keeps the request
// stable until it sees Done and must drop it before the cycle after Done, since
// the DONE cycle itself never samples requests.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int N      = 32,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        SaveMethod,
  input  logic              LoadUnsigned,
  input  logic [N-1:0]      Addr,
  input  logic [N-1:0]      WriteData,
  output logic [N-1:0]      ReadData,
  output logic              Stall,
  output logic              Done,
  output logic              MisalignErr,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        dbg_state
);

  mau_state_t        state, state_nx;
  logic [2:0]        idx;
  logic [2:0]        nbytes;
  logic              is_wr;
  logic              uns_l;
  logic              mis_l;
  logic [MEM_AW-1:0] addr_l;
  logic [N-1:0]      wdata_l;
  logic [3:0][7:0]   rbuf;
  logic [3:0][7:0]   rbuf_fin;
  logic [N-1:0]      ext_data;
  logic              req;
  logic              mis_now;
  logic              last_byte;
  logic [1:0]        cap_sel;
  logic [1:0]        last_sel;
  logic              unused_addr_hi;

  assign req       = MemRead | MemWrite;
  assign last_byte = (idx == (nbytes - 3'd1));
  // RAM data arriving now belongs to the byte issued one cycle earlier.
  assign cap_sel   = 2'(idx - 3'd1);
  assign last_sel  = 2'(nbytes - 3'd1);
  assign dbg_state = state;
  // Address bits above the RAM size are ignored; accesses wrap within the RAM.
  assign unused_addr_hi = ^Addr[N-1:MEM_AW];

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign mis_now = misaligned(SaveMethod, Addr[1:0]);
`else
  assign mis_now = 1'b0;
`endif

  // Merge the final byte straight from the RAM so ReadData can load on DONE entry.
  always_comb begin
    rbuf_fin           = rbuf;
    rbuf_fin[last_sel] = mem_rdata;
  end

  load_extend #(.N(N)) u_load_extend (
    .raw  (rbuf_fin),
    .n    (nbytes),
    .zext (uns_l),
    .data (ext_data)
  );

  // State register, request latch, byte counter and load result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MAU_IDLE;
      idx      <= '0;
      nbytes   <= 3'd1;
      is_wr    <= 1'b0;
      uns_l    <= 1'b0;
      mis_l    <= 1'b0;
      addr_l   <= '0;
      wdata_l  <= '0;
      rbuf     <= '0;
      ReadData <= '0;
    end else begin
      state <= state_nx;
      case (state)
        MAU_IDLE: begin
          if (req) begin
            addr_l  <= Addr[MEM_AW-1:0];
            wdata_l <= WriteData;
            nbytes  <= byte_count(SaveMethod);
            uns_l   <= LoadUnsigned;
            is_wr   <= MemWrite;
            mis_l   <= mis_now;
            idx     <= '0;
          end
        end
        MAU_XFER: begin
          idx <= idx + 3'd1;
          if (!is_wr && (idx != 3'd0)) rbuf[cap_sel] <= mem_rdata;
        end
        MAU_RLAST: ReadData <= ext_data;
        default: ;
      endcase
    end
  end

  // Next-state decode and RAM/handshake outputs; RAM strobes are blocked while
  // rst is high so an aborted store never writes the byte of the reset cycle.
  always_comb begin
    state_nx    = state;
    Stall       = 1'b0;
    Done        = 1'b0;
    MisalignErr = 1'b0;
    mem_addr    = '0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (state)
      MAU_IDLE: begin
        if (req) begin
          Stall    = 1'b1;
          state_nx = mis_now ? MAU_DONE : MAU_XFER;
        end
      end
      MAU_XFER: begin
        Stall = 1'b1;
        if (!rst) begin
          mem_addr = addr_l + MEM_AW'(idx);
          mem_we   = is_wr;
          mem_re   = !is_wr;
          if (is_wr) mem_wdata = wdata_l[{idx[1:0], 3'b000} +: 8];
        end
        if (last_byte) state_nx = is_wr ? MAU_DONE : MAU_RLAST;
      end
      MAU_RLAST: begin
        Stall    = 1'b1;
        state_nx = MAU_DONE;
      end
      MAU_DONE: begin
        Done        = !rst;
        MisalignErr = mis_l & !rst;
        state_nx    = MAU_IDLE;
      end
      default: state_nx = MAU_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a byte-wide RAM model.
// Cycle 0 of an access is the cycle in which the request is first presented.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int N      = 32;
  localparam int MEM_AW = 12;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              MemRead = 1'b0;
  logic              MemWrite = 1'b0;
  logic [1:0]        SaveMethod = 2'b00;
  logic              LoadUnsigned = 1'b0;
  logic [N-1:0]      Addr = '0;
  logic [N-1:0]      WriteData = '0;
  logic [N-1:0]      ReadData;
  logic              Stall;
  logic              Done;
  logic              MisalignErr;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;
  logic [1:0]        dbg_state;

  mem_access_unit #(.N(N), .MEM_AW(MEM_AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .SaveMethod   (SaveMethod),
    .LoadUnsigned (LoadUnsigned),
    .Addr         (Addr),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .Stall        (Stall),
    .Done         (Done),
    .MisalignErr  (MisalignErr),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state)
  );

  // Byte-wide RAM model: write on the edge, read data valid the following cycle.
  logic [7:0] ram [0:4095] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  // Observations of the most recent access
  int          done_cyc;
  int          re_cnt;
  int          we_cnt;
  int          extra_evt;
  logic        mis_seen;
  logic        mis_any;
  logic [31:0] rd_data;
  logic [31:0] stall_mask;
  logic [19:0] wr_q[$];
  logic [11:0] ra_q[$];

  // Scoreboard expectations: {addr, byte} for writes, addr for reads
  logic [19:0] exp_q[$];
  logic [11:0] exp_a_q[$];

  // Driver: present a request, hold it until Done, drop it, then watch 3 idle cycles.
  task automatic run_access(input logic wr, input logic rd, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    done_cyc = -1; re_cnt = 0; we_cnt = 0; extra_evt = 0;
    mis_seen = 1'b0; mis_any = 1'b0; rd_data = '0; stall_mask = '0;
    wr_q.delete(); ra_q.delete();
    @(negedge clk);
    MemWrite = wr; MemRead = rd; SaveMethod = size; LoadUnsigned = uns;
    Addr = addr; WriteData = wdata;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      stall_mask[cyc] = Stall;
      if (MisalignErr) mis_any = 1'b1;
      if (mem_we) begin we_cnt++; wr_q.push_back({mem_addr, mem_wdata}); end
      if (mem_re) begin re_cnt++; ra_q.push_back(mem_addr); end
      if (Done) begin done_cyc = cyc; mis_seen = MisalignErr; rd_data = ReadData; end
      if (done_cyc >= 0) break;
      @(negedge clk);
    end
    MemWrite = 1'b0; MemRead = 1'b0;
    if (done_cyc < 0) begin
      checks++; errors++;
      $display("FAIL access_timeout: got no Done within 20 cycles, want Done");
    end
    repeat (3) begin
      @(negedge clk); #1;
      if (Done || mem_re || mem_we || Stall) extra_evt++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({ReadData, Done, MisalignErr} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h/%b/%b want 0/0/0", ReadData, Done, MisalignErr);
    end
    checks++;
    if ({mem_re, mem_we, mem_addr, mem_wdata, Stall} !== '0) begin
      errors++; $display("FAIL reset_mem_if: got re=%b we=%b addr=%h wd=%h stall=%b want all 0",
                         mem_re, mem_we, mem_addr, mem_wdata, Stall);
    end
    checks++;
    if (dbg_state !== MAU_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, MAU_IDLE);
    end
    rst = 1'b0;
  endtask

  task automatic test_store_word();
    logic [19:0] e, g;
    run_access(1'b1, 1'b0, SIZE_W, 1'b0, 32'h10, 32'hDEADBEEF);
    exp_q.delete();
    exp_q.push_back({12'h010, 8'hEF}); exp_q.push_back({12'h011, 8'hBE});
    exp_q.push_back({12'h012, 8'hAD}); exp_q.push_back({12'h013, 8'hDE});
    checks++;
    if (done_cyc !== 5) begin errors++; $display("FAIL sw_done_cycle: got %0d want 5", done_cyc); end
    checks++;
    if (stall_mask[5:0] !== 6'b011111) begin
      errors++; $display("FAIL sw_stall: got %b want 011111", stall_mask[5:0]);
    end
    checks++;
    if (we_cnt !== 4 || re_cnt !== 0) begin
      errors++; $display("FAIL sw_strobes: got we=%0d re=%0d want we=4 re=0", we_cnt, re_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (wr_q.size() > 0) ? wr_q.pop_front() : 20'hxxxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL sw_byte: got %h want %h", g, e); end
    end
    checks++;
    if ({ram[12'h013], ram[12'h012], ram[12'h011], ram[12'h010]} !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_ram: got %h%h%h%h want deadbeef",
                         ram[12'h013], ram[12'h012], ram[12'h011], ram[12'h010]);
    end
    checks++;
    if (extra_evt !== 0) begin errors++; $display("FAIL sw_single: got %0d extra events want 0", extra_evt); end
  endtask

  task automatic test_load_byte();
    run_access(1'b1, 1'b0, SIZE_B, 1'b0, 32'h20, 32'h00000080);
    run_access(1'b0, 1'b1, SIZE_B, 1'b0, 32'h20, 32'h0);
    checks++;
    if (done_cyc !== 3) begin errors++; $display("FAIL lb_done_cycle: got %0d want 3", done_cyc); end
    checks++;
    if (rd_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", rd_data); end
    checks++;
    if (re_cnt !== 1 || we_cnt !== 0 || stall_mask[3:0] !== 4'b0111) begin
      errors++; $display("FAIL lb_strobes: got re=%0d we=%0d stall=%b want 1 0 0111", re_cnt, we_cnt, stall_mask[3:0]);
    end
    run_access(1'b0, 1'b1, SIZE_B, 1'b1, 32'h20, 32'h0);
    checks++;
    if (rd_data !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h want 00000080", rd_data); end
    checks++;
    if (ReadData !== 32'h00000080) begin errors++; $display("FAIL lbu_hold: got %h want 00000080", ReadData); end
  endtask

  task automatic test_load_half();
    logic [11:0] ea, ga;
    run_access(1'b1, 1'b0, SIZE_H, 1'b0, 32'h30, 32'h00001234);
    run_access(1'b0, 1'b1, SIZE_H, 1'b0, 32'h30, 32'h0);
    checks++;
    if (done_cyc !== 4) begin errors++; $display("FAIL lh_done_cycle: got %0d want 4", done_cyc); end
    checks++;
    if (rd_data !== 32'h00001234) begin errors++; $display("FAIL lh_data: got %h want 00001234", rd_data); end
    exp_a_q.delete(); exp_a_q.push_back(12'h030); exp_a_q.push_back(12'h031);
    while (exp_a_q.size() > 0) begin
      ea = exp_a_q.pop_front();
      ga = (ra_q.size() > 0) ? ra_q.pop_front() : 12'hxxx;
      checks++;
      if (ga !== ea) begin errors++; $display("FAIL lh_addr: got %h want %h", ga, ea); end
    end
    run_access(1'b1, 1'b0, SIZE_B, 1'b0, 32'h31, 32'h00000092);
    run_access(1'b0, 1'b1, SIZE_H, 1'b1, 32'h30, 32'h0);
    checks++;
    if (rd_data !== 32'h00009234) begin errors++; $display("FAIL lhu_data: got %h want 00009234", rd_data); end
    run_access(1'b0, 1'b1, SIZE_H, 1'b0, 32'h30, 32'h0);
    checks++;
    if (rd_data !== 32'hFFFF9234) begin errors++; $display("FAIL lh_neg_data: got %h want ffff9234", rd_data); end
  endtask

  task automatic test_store_keeps_readdata();
    run_access(1'b1, 1'b0, SIZE_B, 1'b0, 32'h40, 32'h0000005A);
    checks++;
    if (done_cyc !== 2) begin errors++; $display("FAIL sb_done_cycle: got %0d want 2", done_cyc); end
    checks++;
    if (rd_data !== 32'hFFFF9234) begin errors++; $display("FAIL sb_readdata_kept: got %h want ffff9234", rd_data); end
    checks++;
    if (ram[12'h040] !== 8'h5A) begin errors++; $display("FAIL sb_ram: got %h want 5a", ram[12'h040]); end
  endtask

  task automatic test_both_requests();
    run_access(1'b1, 1'b1, SIZE_H, 1'b0, 32'h44, 32'h0000BEEF);
    checks++;
    if (re_cnt !== 0 || we_cnt !== 2) begin
      errors++; $display("FAIL both_strobes: got re=%0d we=%0d want re=0 we=2", re_cnt, we_cnt);
    end
    checks++;
    if (done_cyc !== 3) begin errors++; $display("FAIL both_done_cycle: got %0d want 3", done_cyc); end
    checks++;
    if ({ram[12'h045], ram[12'h044]} !== 16'hBEEF) begin
      errors++; $display("FAIL both_ram: got %h%h want beef", ram[12'h045], ram[12'h044]);
    end
    checks++;
    if (extra_evt !== 0) begin errors++; $display("FAIL both_single: got %0d extra events want 0", extra_evt); end
  endtask

  task automatic test_wrap();
    logic [11:0] ea, ga;
    run_access(1'b1, 1'b0, SIZE_B, 1'b0, 32'hFFE, 32'h11);
    run_access(1'b1, 1'b0, SIZE_B, 1'b0, 32'hFFF, 32'h22);
    run_access(1'b1, 1'b0, SIZE_B, 1'b0, 32'h000, 32'h33);
    run_access(1'b1, 1'b0, SIZE_B, 1'b0, 32'h001, 32'h44);
    run_access(1'b0, 1'b1, SIZE_W, 1'b0, 32'hFFE, 32'h0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    checks++;
    if (done_cyc !== 1) begin errors++; $display("FAIL trap_done_cycle: got %0d want 1", done_cyc); end
    checks++;
    if (mis_seen !== 1'b1) begin errors++; $display("FAIL trap_flag: got %b want 1", mis_seen); end
    checks++;
    if (re_cnt !== 0 || we_cnt !== 0) begin
      errors++; $display("FAIL trap_no_access: got re=%0d we=%0d want 0 0", re_cnt, we_cnt);
    end
    checks++;
    if (rd_data !== 32'hFFFF9234) begin errors++; $display("FAIL trap_readdata: got %h want ffff9234", rd_data); end
    run_access(1'b1, 1'b0, SIZE_W, 1'b0, 32'hFFE, 32'hCAFEF00D);
    checks++;
    if (we_cnt !== 0 || ram[12'hFFE] !== 8'h11) begin
      errors++; $display("FAIL trap_store: got we=%0d ram=%h want 0 11", we_cnt, ram[12'hFFE]);
    end
`else
    checks++;
    if (done_cyc !== 6) begin errors++; $display("FAIL wrap_done_cycle: got %0d want 6", done_cyc); end
    checks++;
    if (rd_data !== 32'h44332211) begin errors++; $display("FAIL wrap_data: got %h want 44332211", rd_data); end
    checks++;
    if (mis_any !== 1'b0) begin errors++; $display("FAIL wrap_no_trap: got %b want 0", mis_any); end
    exp_a_q.delete();
    exp_a_q.push_back(12'hFFE); exp_a_q.push_back(12'hFFF);
    exp_a_q.push_back(12'h000); exp_a_q.push_back(12'h001);
    while (exp_a_q.size() > 0) begin
      ea = exp_a_q.pop_front();
      ga = (ra_q.size() > 0) ? ra_q.pop_front() : 12'hxxx;
      checks++;
      if (ga !== ea) begin errors++; $display("FAIL wrap_addr: got %h want %h", ga, ea); end
    end
`endif
  endtask

  task automatic test_reset_abort();
    int seen_done;
    seen_done = 0;
    @(negedge clk);
    MemWrite = 1'b1; SaveMethod = SIZE_W; LoadUnsigned = 1'b0;
    Addr = 32'h50; WriteData = 32'hA1B2C3D4;
    repeat (3) begin
      #1; if (Done) seen_done++;
      @(negedge clk);
    end
    rst = 1'b1; MemWrite = 1'b0;
    #1;
    if (Done) seen_done++;
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_we_blocked: got %b want 0", mem_we); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (Done) seen_done++;
    checks++;
    if (dbg_state !== MAU_IDLE || Stall !== 1'b0 || mem_addr !== '0) begin
      errors++; $display("FAIL abort_idle: got state=%0d stall=%b addr=%h want 0 0 0", dbg_state, Stall, mem_addr);
    end
    checks++;
    if (ReadData !== '0) begin errors++; $display("FAIL abort_readdata: got %h want 0", ReadData); end
    repeat (2) begin @(negedge clk); #1; if (Done) seen_done++; end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", seen_done); end
    checks++;
    if ({ram[12'h053], ram[12'h052], ram[12'h051], ram[12'h050]} !== 32'h0000C3D4) begin
      errors++; $display("FAIL abort_ram: got %h%h%h%h want 0000c3d4",
                         ram[12'h053], ram[12'h052], ram[12'h051], ram[12'h050]);
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_load_half();
    test_store_keeps_readdata();
    test_both_requests();
    test_wrap();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side consumer of the control unit's MemRead/MemWrite/SaveMethod signals.
- Executes RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) against a single-port, byte-wide data RAM, one byte per cycle, little-endian.
- Stalls the pipeline while busy.
- Returns sign- or zero-extended load data with a one-cycle Done pulse.

Parameters:
- N, 32, datapath width (address and data).
- MEM_AW, 12, byte-address width of the data RAM.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- MemRead  in  1  load request from control unit
- MemWrite  in  1  store request from control unit
- SaveMethod  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- LoadUnsigned  in  1  funct3[2]; 1 = zero-extend load
- Addr  in  N  byte address (ALU result)
- WriteData  in  N  store data (rs2)
- ReadData  out  N  extended load result
- Stall  out  1  hold pipeline
- Done  out  1  one-cycle completion pulse
- MisalignErr  out  1  one-cycle misalignment pulse
- mem_addr  out  MEM_AW  RAM byte address
- mem_re  out  1  RAM read enable
- mem_we  out  1  RAM write enable
- mem_wdata  out  8  RAM write byte
- mem_rdata  in  8  RAM read byte, valid the cycle after mem_re

Behaviour:
- Clocking/reset: single clock clk; rst is synchronous, active-high.
- Reset (or rst asserted mid-operation): state=IDLE; ReadData, Done, MisalignErr, mem_re, mem_we, mem_addr, mem_wdata = 0.
  - An aborted store leaves bytes already written in RAM; no Done pulse is produced.
- States: IDLE, XFER, RLAST, DONE.
- Byte count n: 1 for 00, 2 for 01, 4 for 10/11. Byte i goes to mem_addr = (Addr+i) mod 2^MEM_AW; wraps silently.
- IDLE:
  - If MemWrite|MemRead: latch Addr, WriteData, size, LoadUnsigned, and direction; i=0; go to XFER.
  - If both are asserted, MemWrite wins and the read is ignored.
- Stall = (IDLE & (MemRead|MemWrite)) | XFER | RLAST. It is combinational so the request cycle already stalls. Stall=0 in DONE.
- XFER, store: each cycle mem_we=1, mem_wdata=byte i of latched data; i++. After byte n-1, go to DONE.
  - Done rises n+1 cycles after acceptance.
- XFER, load: each cycle mem_re=1 for byte i. mem_rdata (byte i-1) is captured into a byte buffer when i>0. After issuing byte n-1, go to RLAST.
- RLAST: capture final byte; go to DONE.
- DONE: Done=1 for exactly one cycle; go to IDLE.
  - Requests are not sampled in DONE, because the pipeline still presents the same instruction.
  - Load: ReadData registered on DONE entry, bits above 8n = LoadUnsigned ? 0 : bit (8n-1). Done rises n+2 cycles after acceptance.
  - ReadData holds until the next completed load. Stores leave it unchanged.
- mem_re and mem_we are never asserted together; both are 0 outside XFER.

Optional Feature:
- MEM_ACCESS_MISALIGN_TRAP_EN defined: a half access with Addr[0]≠0, or a word access with Addr[1:0]≠0, performs no RAM access.
  - IDLE→DONE directly: MisalignErr=1 and Done=1 in the DONE cycle; ReadData unchanged.
- Undefined: misaligned accesses complete byte-serially as normal; MisalignErr tied 0.

Decomposition:
- Shared defines file gets:
  - size codes SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10;
  - state encodings MAU_IDLE/XFER/RLAST/DONE.
- Optional sub-module load_extend: combinational (bytes[31:0], n, unsigned) → ReadData. Reused by any future cache path.

Test Plan:
- SW: Addr=0x10, WriteData=0xDEADBEEF → mem_we on 0x10..0x13 with EF,BE,AD,DE in 4 consecutive cycles; Done at cycle 5; Stall high on cycles 0-4.
- LB signed: RAM[0x20]=0x80 → ReadData=0xFFFFFF80, Done at cycle 3. LBU same byte → 0x00000080.
- LH: RAM[0x30..0x31]=0x34,0x12 → ReadData=0x00001234, Done at cycle 4. LH with RAM[0x31]=0x92 → 0xFFFF9234.
- Wrap: LW Addr=0xFFE with MEM_AW=12 → bytes read from 0xFFE,0xFFF,0x000,0x001. Without the macro the access completes normally; with the macro, MisalignErr=1, no RAM access, Done at cycle 1.
- rst during SW after 2 bytes → next cycle idle, outputs 0, no Done; only RAM[Addr], RAM[Addr+1] modified.
- MemRead=MemWrite=1 → store performed, no mem_re pulses. Request held through DONE → exactly one access, one Done.
